// File: rtl/spi_pkg.sv
// Shared SPI definitions: byte width and the receive/transmit FSM state encoding.
package spi_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = $clog2(BYTE_W);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Receive byte buffer. SPI_RX_FIFO_EN selects a DEPTH-entry FIFO; otherwise a
// single holding register is used and DEPTH is ignored.
module spi_rx_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [BYTE_W-1:0] i_push_data,
    input  logic              i_pop_ready,
    output logic [BYTE_W-1:0] o_byte_out,
    output logic              o_byte_valid,
    output logic              o_overflow
);

    logic [BYTE_W-1:0] r_byte_out;
    logic              r_valid;
    logic              r_overflow;
    logic              w_pop;

    assign w_pop        = r_valid & i_pop_ready;
    assign o_byte_out   = r_byte_out;
    assign o_byte_valid = r_valid;
    assign o_overflow   = r_overflow;

`ifdef SPI_RX_FIFO_EN
    localparam int PW = $clog2(DEPTH);

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW:0]       r_count;
    logic              w_full;
    logic              w_wr;
    logic [PW-1:0]     w_rd_next;
    logic [PW:0]       w_count_next;

    assign w_full       = (r_count == (PW+1)'(DEPTH));
    assign w_wr         = i_push & (~w_full | w_pop);
    assign w_rd_next    = r_rd_ptr + PW'(w_pop);
    assign w_count_next = r_count + (PW+1)'(w_wr) - (PW+1)'(w_pop);

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= i_push_data;
    end

    // The head register is reloaded every cycle; a byte written into an
    // otherwise empty buffer bypasses the array so it appears one cycle later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_byte_out <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_valid  <= (w_count_next != '0);
            if (w_count_next != '0) begin
                if (w_wr && (r_wr_ptr == w_rd_next))
                    r_byte_out <= i_push_data;
                else
                    r_byte_out <= r_mem[w_rd_next];
            end
            if (i_push && w_full && !w_pop)
                r_overflow <= 1'b1;
        end
    end
`else
    logic w_unused_depth;
    assign w_unused_depth = DEPTH[0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_byte_out <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (i_push) begin
                if (!r_valid || w_pop) begin
                    r_byte_out <= i_push_data;
                    r_valid    <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: rtl/spi_byte_receiver.sv
// SPI byte receiver: synchronizes an external LSB-first SPI stream into clk and
// buffers whole bytes. Optional FIFO buffering via macro SPI_RX_FIFO_EN.
module spi_byte_receiver
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_en,
    input  logic              spi_din,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              overflow,
    output logic              frame_err
);

    // Per stage: bit 2 = spi_clk, bit 1 = spi_en, bit 0 = spi_din.
    logic [SYNC_STAGES-1:0][2:0] r_sync;
    logic [SYNC_STAGES-1:0]      r_sync_vld;
    logic                        r_clk_prev;
    logic                        w_clk_s;
    logic                        w_en_s;
    logic                        w_din_s;
    logic                        w_edge;

    spi_state_t                  r_state;
    logic [BIT_CNT_W-1:0]        r_bit_cnt;
    logic [BYTE_W-1:0]           r_shift;
    logic                        r_push;
    logic                        r_frame_err;
    logic                        r_armed;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync     <= '0;
            r_sync_vld <= '0;
            r_clk_prev <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], {spi_clk, spi_en, spi_din}};
            r_sync_vld <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
            r_clk_prev <= w_clk_s;
        end
    end

    assign w_clk_s = r_sync[SYNC_STAGES-1][2];
    assign w_en_s  = r_sync[SYNC_STAGES-1][1];
    assign w_din_s = r_sync[SYNC_STAGES-1][0];
    assign w_edge  = w_clk_s & ~r_clk_prev;

    // r_armed stays low after reset until a genuine low spi_en has crossed the
    // synchronizer, so a frame already running at reset release is ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (!r_armed) begin
                        if (r_sync_vld[SYNC_STAGES-1] && !w_en_s)
                            r_armed <= 1'b1;
                    end else if (w_en_s) begin
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!w_en_s) begin
                        r_state   <= IDLE;
                        r_bit_cnt <= '0;
                        if (r_bit_cnt != '0)
                            r_frame_err <= 1'b1;
                    end else if (w_edge) begin
                        r_shift[r_bit_cnt] <= w_din_s;
                        r_bit_cnt          <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == BIT_CNT_W'(BYTE_W - 1))
                            r_push <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign frame_err = r_frame_err;

    spi_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (r_push),
        .i_push_data  (r_shift),
        .i_pop_ready  (byte_ready),
        .o_byte_out   (byte_out),
        .o_byte_valid (byte_valid),
        .o_overflow   (overflow)
    );

endmodule

// File: doc/spi_byte_receiver.md
SPI_BYTE_RECEIVER -- requirements
Module: spi_byte_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for spi_clk, spi_en and spi_din; legal 2..4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: byte buffer depth when SPI_RX_FIFO_EN is defined; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1, system clock; reset rst, synchronous, active-low.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have port spi_clk, input, 1, serial clock from the upstream transmitter, asynchronous to clk, at most clk/4.
REQ-006 SHALL have port spi_en, input, 1, frame enable; high while the transmitter is talking.
REQ-007 SHALL have port spi_din, input, 1, serial data, LSB first.
REQ-008 SHALL have port byte_out, output, 8, received byte at the buffer head.
REQ-009 SHALL have port byte_valid, output, 1, byte_out holds a valid byte.
REQ-010 SHALL have port byte_ready, input, 1, consumer accepts; transfer when byte_valid and byte_ready are both high at a clk edge.
REQ-011 SHALL have port overflow, output, 1, sticky; a completed byte was dropped.
REQ-012 SHALL have port frame_err, output, 1, one-cycle pulse; spi_en fell mid-byte.

Function
REQ-013 SHALL pass spi_clk, spi_en and spi_din each through a SYNC_STAGES flop chain before use.
REQ-014 SHALL detect a spi_clk rising edge as synced spi_clk high with its previous-cycle value low.
REQ-015 SHALL implement FSM states IDLE and SHIFT; IDLE->SHIFT when synced spi_en is high; SHIFT->IDLE when synced spi_en is low.
REQ-016 SHALL, in SHIFT on each detected edge, place synced spi_din into bit position bit_cnt (3-bit counter, 0..7); first bit lands in bit 0.
REQ-017 SHALL, on the edge where bit_cnt is 7, push the completed byte, wrap bit_cnt to 0 and stay in SHIFT; back-to-back bytes need no gap.
REQ-018 SHALL ignore spi_clk edges while in IDLE.
REQ-019 SHALL, on a SHIFT->IDLE transition with bit_cnt nonzero, pulse frame_err for one cycle, discard the partial byte and clear bit_cnt.
REQ-020 SHALL present a pushed byte on byte_out with byte_valid high on the clk cycle after the push.
REQ-021 SHALL keep byte_out and byte_valid stable while byte_valid is high and byte_ready is low.
REQ-022 SHALL, on a push with the buffer full and no pop in the same cycle, drop the new byte, keep buffer contents and set overflow.
REQ-023 SHALL, on simultaneous push and pop with the buffer full, accept both with no overflow.

Reset
REQ-024 SHALL, with rst low at a clk edge, clear byte_out to 8'h00, byte_valid, overflow and frame_err to 0, state to IDLE, bit_cnt to 0, the buffer to empty and all synchronizer flops to 0.
REQ-025 SHALL, on reset mid-byte, discard the partial byte without a frame_err pulse.
REQ-026 SHALL, after rst rises, ignore any frame already in progress (spi_en synced high) until spi_en is seen low, then return to IDLE.

Configuration
REQ-027 SHALL, with SPI_RX_FIFO_EN defined, buffer bytes in a FIFO_DEPTH-entry FIFO with wrapping pointers and a count one bit wider than the pointers.
REQ-028 SHALL, without SPI_RX_FIFO_EN, use a single holding register; full equals byte_valid; FIFO_DEPTH is ignored.

Structure
REQ-029 SHALL take the FSM state encoding (IDLE, SHIFT) and the byte width constant 8 from the shared spi_pkg package used by the transmitter.
REQ-030 SHALL put the buffer in sub-module spi_rx_fifo, whose behaviour is selected by SPI_RX_FIFO_EN.

Verification
REQ-031 SHALL cover this scenario: send 8'hA5 LSB first with byte_ready high -> one byte_valid pulse, byte_out 8'hA5, frame_err 0.
REQ-032 SHALL cover this scenario: send 8'h3C then 8'hC3 back-to-back under one spi_en -> two bytes, in order, no frame_err.
REQ-033 SHALL cover this scenario: drop spi_en after 5 bits -> frame_err pulse of exactly one cycle, no byte pushed, next full byte 8'h01 received correctly.
REQ-034 SHALL cover this scenario: SPI_RX_FIFO_EN with FIFO_DEPTH 4, byte_ready low, send 8'h01..8'h05 -> overflow set on the fifth byte; popping yields 8'h01..8'h04.
REQ-035 SHALL cover this scenario: SPI_RX_FIFO_EN undefined, byte_ready low, send 8'h11 then 8'h22 -> overflow set, byte_out holds 8'h11.
REQ-036 SHALL cover this scenario: assert rst after bit 3 of a byte -> all outputs 0 next cycle, no frame_err, next frame 8'hFF received correctly.
